// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared types and constants for the VeriRISC fetch/execute sequencer
package cpu_seq_pkg;

   // Sequencer states; encodings 9..15 are illegal and recover to INST_ADDR
   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8
   } state_e;

   // Instruction codes; SKNZ only exists in builds with CPU_SEQ_SKNZ_EN and OPCODE_W>=4
   typedef enum logic [3:0] {
      OP_HLT  = 4'd0,
      OP_SKZ  = 4'd1,
      OP_ADD  = 4'd2,
      OP_AND  = 4'd3,
      OP_XOR  = 4'd4,
      OP_LDA  = 4'd5,
      OP_STO  = 4'd6,
      OP_JMP  = 4'd7,
      OP_SKNZ = 4'd8
   } opcode_e;

   // Datapath strobes, MSB first
   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic halt;
      logic inc_pc;
      logic ld_ac;
      logic ld_pc;
      logic wr;
      logic data_e;
   } ctrl_t;

   // Strobe values while reset is held: instruction address on the bus, nothing else
   localparam ctrl_t CTRL_RESET = '{sel: 1'b1, default: 1'b0};

endpackage

// File: rtl/cpu_seq_wait_cnt.sv
// rtl/cpu_seq_wait_cnt.sv - 4-bit load/decrement memory wait counter with done flag
module cpu_seq_wait_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       done
);

   logic [3:0] count;

   // Load on the cycle before a wait state, then count down and stick at zero
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   assign done = (count == 4'd0);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - VeriRISC sequencer with wait states, resumable halt; CPU_SEQ_SKNZ_EN adds SKNZ (opcode 8)
module cpu_seq_ctrl
   import cpu_seq_pkg::*;
#(
   parameter int OPCODE_W    = 3,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                go,
   output logic                sel,
   output logic                rd,
   output logic                ld_ir,
   output logic                halt,
   output logic                inc_pc,
   output logic                ld_ac,
   output logic                ld_pc,
   output logic                wr,
   output logic                data_e,
   output logic [3:0]          state
);

   state_e      cur;
   ctrl_t       strb;
   logic        wait_done;
   logic        wait_load;
   logic        wait_dec;
   logic [31:0] op_ext;
   logic        is_hlt;
   logic        is_skz;
   logic        is_sto;
   logic        is_jmp;
   logic        is_alu;
   logic        is_sknz;

   // Compare at 32 bits so code 8 can never alias a low opcode in a 3-bit build
   assign op_ext = 32'(opcode);
   assign is_hlt = (op_ext == 32'(OP_HLT));
   assign is_skz = (op_ext == 32'(OP_SKZ));
   assign is_sto = (op_ext == 32'(OP_STO));
   assign is_jmp = (op_ext == 32'(OP_JMP));
   assign is_alu = (op_ext == 32'(OP_ADD)) || (op_ext == 32'(OP_AND)) ||
                   (op_ext == 32'(OP_XOR)) || (op_ext == 32'(OP_LDA));

`ifdef CPU_SEQ_SKNZ_EN
   assign is_sknz = (OPCODE_W >= 4) && (op_ext == 32'(OP_SKNZ));
`else
   assign is_sknz = 1'b0;
`endif

   // One counter serves both wait states: armed in the state before each, drained inside
   assign wait_load = (cur == INST_ADDR) || (cur == OP_ADDR);
   assign wait_dec  = (cur == INST_FETCH) || (cur == OP_FETCH);

   cpu_seq_wait_cnt u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (wait_load),
      .load_val (4'(WAIT_CYCLES)),
      .dec      (wait_dec),
      .done     (wait_done)
   );

   // Instruction sequencing; any unlisted encoding falls back to INST_ADDR
   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= INST_ADDR;
      end else begin
         case (cur)
            INST_ADDR:  cur <= INST_FETCH;
            INST_FETCH: if (wait_done) cur <= INST_LOAD;
            INST_LOAD:  cur <= IDLE;
            IDLE:       cur <= OP_ADDR;
            OP_ADDR:    cur <= is_hlt ? HALTED : OP_FETCH;
            OP_FETCH:   if (wait_done) cur <= ALU_OP;
            ALU_OP:     cur <= STORE;
            STORE:      cur <= INST_ADDR;
            HALTED:     if (go) cur <= INST_ADDR;
            default:    cur <= INST_ADDR;
         endcase
      end
   end

   // Strobe decode from state, opcode and zero; reset overrides so no write escapes
   always_comb begin
      strb = '0;
      if (reset) begin
         strb = CTRL_RESET;
      end else begin
         case (cur)
            INST_ADDR: begin
               strb.sel = 1'b1;
            end
            INST_FETCH: begin
               strb.sel = 1'b1;
               strb.rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               strb.sel   = 1'b1;
               strb.rd    = 1'b1;
               strb.ld_ir = 1'b1;
            end
            OP_ADDR: begin
               strb.inc_pc = 1'b1;
               strb.halt   = is_hlt;
            end
            OP_FETCH: begin
               strb.rd = is_alu;
            end
            ALU_OP: begin
               strb.rd     = is_alu;
               strb.inc_pc = (is_skz && zero) || (is_sknz && !zero);
               strb.ld_pc  = is_jmp;
               strb.data_e = is_sto;
            end
            STORE: begin
               strb.rd     = is_alu;
               strb.ld_ac  = is_alu;
               strb.ld_pc  = is_jmp;
               strb.wr     = is_sto;
               strb.data_e = is_sto;
            end
            HALTED: begin
               strb.halt = 1'b1;
            end
            default: begin
               strb = '0;
            end
         endcase
      end
   end

   assign sel    = strb.sel;
   assign rd     = strb.rd;
   assign ld_ir  = strb.ld_ir;
   assign halt   = strb.halt;
   assign inc_pc = strb.inc_pc;
   assign ld_ac  = strb.ld_ac;
   assign ld_pc  = strb.ld_pc;
   assign wr     = strb.wr;
   assign data_e = strb.data_e;
   assign state  = cur;

endmodule
